lcd_init_seq_param: RTL

//  Parametrised ST7735-class SPI-LCD power-up sequencer and screen-fill engine.

---
 rtl/lcd_init_seq_param.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_init_seq_param.sv
// ST7735-class panel power-up sequencer and full-window fill engine.
// Emits {dc,byte} one at a time to a byte-level SPI writer, advancing on wr_done.
module lcd_init_seq_param #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned T_RSTL_MS  = 20,
  parameter int unsigned T_RSTH_MS  = 20,
  parameter int unsigned T_SLP_MS   = 5,
  parameter int unsigned WIDTH      = 128,
  parameter int unsigned HEIGHT     = 160,
  parameter int unsigned X_OFS      = 0,
  parameter int unsigned Y_OFS      = 0,
  parameter logic [7:0]  MADCTL     = 8'hC0,
  parameter logic [15:0] FILL_COLOR = 16'h0010
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_done,
  input  logic        fill_req,
  input  logic [15:0] fill_color,
  output logic        lcd_rst,
  output logic [8:0]  init_data,
  output logic        en_write,
  output logic        busy,
  output logic        init_done,
  output logic        fill_done
);

  localparam int unsigned CYC_PER_MS = CLK_HZ / 1000;
  localparam int unsigned T_RSTL     = CYC_PER_MS * T_RSTL_MS;
  localparam int unsigned T_RSTH     = CYC_PER_MS * T_RSTH_MS;
  localparam int unsigned T_SLP      = CYC_PER_MS * T_SLP_MS;
  localparam int unsigned T_MAX0     = (T_RSTL > T_RSTH) ? T_RSTL : T_RSTH;
  localparam int unsigned T_MAX      = (T_MAX0 > T_SLP) ? T_MAX0 : T_SLP;
  localparam int          DLY_W      = (T_MAX < 2) ? 1 : $clog2(T_MAX);

  // A zero-length delay degenerates to a single cycle.
  localparam logic [DLY_W-1:0] RSTL_LAST = DLY_W'((T_RSTL > 0) ? T_RSTL - 1 : 0);
  localparam logic [DLY_W-1:0] RSTH_LAST = DLY_W'((T_RSTH > 0) ? T_RSTH - 1 : 0);
  localparam logic [DLY_W-1:0] SLP_LAST  = DLY_W'((T_SLP > 0) ? T_SLP - 1 : 0);

  localparam int unsigned      PIX_BYTES = WIDTH * HEIGHT * 2;
  localparam int               PIX_W     = $clog2(PIX_BYTES + 1);
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_BYTES - 1);

  localparam logic [15:0] XS = 16'(X_OFS);
  localparam logic [15:0] XE = 16'(X_OFS + WIDTH - 1);
  localparam logic [15:0] YS = 16'(Y_OFS);
  localparam logic [15:0] YE = 16'(Y_OFS + HEIGHT - 1);

  localparam logic [3:0] HDR_PIX = 4'd11;  // header index meaning "streaming pixels"

  localparam int         INIT_LEN  = 77;
  localparam logic [6:0] INIT_LAST = 7'(INIT_LEN - 1);

  // Bit 8 set marks a data byte, clear marks a command byte.
  localparam logic [8:0] INIT_ROM [INIT_LEN] = '{
    9'h0B1, 9'h101, 9'h12C, 9'h12D,
    9'h0B2, 9'h101, 9'h12C, 9'h12D,
    9'h0B3, 9'h101, 9'h12C, 9'h12D, 9'h101, 9'h12C, 9'h12D,
    9'h0B4, 9'h107,
    9'h0C0, 9'h1A2, 9'h102, 9'h184,
    9'h0C1, 9'h1C5,
    9'h0C2, 9'h10A, 9'h100,
    9'h0C3, 9'h18A, 9'h12A,
    9'h0C4, 9'h18A, 9'h1EE,
    9'h0C5, 9'h10E,
    9'h036, {1'b1, MADCTL},
    9'h0E0, 9'h10F, 9'h11A, 9'h10F, 9'h118, 9'h12F, 9'h128, 9'h120, 9'h122,
            9'h11F, 9'h11B, 9'h123, 9'h137, 9'h100, 9'h107, 9'h102, 9'h110,
    9'h0E1, 9'h10F, 9'h11B, 9'h10F, 9'h117, 9'h133, 9'h12C, 9'h129, 9'h12E,
            9'h130, 9'h130, 9'h139, 9'h13F, 9'h100, 9'h107, 9'h103, 9'h110,
    9'h0F0, 9'h101,
    9'h0F6, 9'h100,
    9'h03A, 9'h105,
    9'h029
  };

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_HIGH,
    ST_SLPOUT,
    ST_SLP_WAIT,
    ST_INIT,
    ST_FILL,
    ST_IDLE
  } state_t;

  state_t           state_reg,     state_next;
  logic [DLY_W-1:0] dly_cnt_reg,   dly_cnt_next;
  logic [6:0]       init_idx_reg,  init_idx_next;
  logic [3:0]       hdr_cnt_reg,   hdr_cnt_next;
  logic [PIX_W-1:0] pix_cnt_reg,   pix_cnt_next;
  logic [15:0]      color_reg,     color_next;
  logic             pending_reg,   pending_next;
  logic             lcd_rst_reg,   lcd_rst_next;
  logic [8:0]       init_data_reg, init_data_next;
  logic             en_write_reg,  en_write_next;
  logic             init_done_reg, init_done_next;
  logic             fill_done_reg, fill_done_next;

  // Window header followed by the pixel stream, high byte of each pixel first.
  function automatic logic [8:0] fill_byte(input logic [3:0] hdr, input logic pix_lsb,
                                           input logic [15:0] color);
    logic [8:0] b;
    case (hdr)
      4'd0:    b = 9'h02A;
      4'd1:    b = {1'b1, XS[15:8]};
      4'd2:    b = {1'b1, XS[7:0]};
      4'd3:    b = {1'b1, XE[15:8]};
      4'd4:    b = {1'b1, XE[7:0]};
      4'd5:    b = 9'h02B;
      4'd6:    b = {1'b1, YS[15:8]};
      4'd7:    b = {1'b1, YS[7:0]};
      4'd8:    b = {1'b1, YE[15:8]};
      4'd9:    b = {1'b1, YE[7:0]};
      4'd10:   b = 9'h02C;
      default: b = pix_lsb ? {1'b1, color[7:0]} : {1'b1, color[15:8]};
    endcase
    return b;
  endfunction

  always_comb begin
    state_next     = state_reg;
    dly_cnt_next   = dly_cnt_reg;
    init_idx_next  = init_idx_reg;
    hdr_cnt_next   = hdr_cnt_reg;
    pix_cnt_next   = pix_cnt_reg;
    color_next     = color_reg;
    pending_next   = pending_reg;
    init_done_next = init_done_reg;
    fill_done_next = 1'b0;

    // One-deep request memory; the colour is taken later, at acceptance.
    if (fill_req && (state_reg != ST_IDLE)) begin
      pending_next = 1'b1;
    end

    case (state_reg)
      ST_RST_LOW: begin
        if (dly_cnt_reg == RSTL_LAST) begin
          state_next   = ST_RST_HIGH;
          dly_cnt_next = '0;
        end else begin
          dly_cnt_next = dly_cnt_reg + 1'b1;
        end
      end
      ST_RST_HIGH: begin
        if (dly_cnt_reg == RSTH_LAST) begin
          state_next   = ST_SLPOUT;
          dly_cnt_next = '0;
        end else begin
          dly_cnt_next = dly_cnt_reg + 1'b1;
        end
      end
      ST_SLPOUT: begin
        if (wr_done) begin
          state_next   = ST_SLP_WAIT;
          dly_cnt_next = '0;
        end
      end
      ST_SLP_WAIT: begin
        if (dly_cnt_reg == SLP_LAST) begin
          state_next    = ST_INIT;
          dly_cnt_next  = '0;
          init_idx_next = '0;
        end else begin
          dly_cnt_next = dly_cnt_reg + 1'b1;
        end
      end
      ST_INIT: begin
        if (wr_done) begin
          if (init_idx_reg == INIT_LAST) begin
            state_next   = ST_FILL;
            hdr_cnt_next = '0;
            pix_cnt_next = '0;
            color_next   = FILL_COLOR;
          end else begin
            init_idx_next = init_idx_reg + 7'd1;
          end
        end
      end
      ST_FILL: begin
        if (wr_done) begin
          if (hdr_cnt_reg != HDR_PIX) begin
            hdr_cnt_next = hdr_cnt_reg + 4'd1;
          end else if (pix_cnt_reg == PIX_LAST) begin
            state_next     = ST_IDLE;
            fill_done_next = 1'b1;
            init_done_next = 1'b1;
          end else begin
            pix_cnt_next = pix_cnt_reg + 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (fill_req || pending_reg) begin
          state_next   = ST_FILL;
          hdr_cnt_next = '0;
          pix_cnt_next = '0;
          color_next   = fill_color;
          pending_next = 1'b0;
        end
      end
      default: state_next = ST_RST_LOW;
    endcase

    // Outputs are registered from the next-state view so byte and strobe stay aligned.
    lcd_rst_next  = lcd_rst_reg | (state_next == ST_RST_HIGH);
    en_write_next = (state_next == ST_SLPOUT) || (state_next == ST_INIT) ||
                    (state_next == ST_FILL);
    case (state_next)
      ST_SLPOUT: init_data_next = 9'h011;
      ST_INIT:   init_data_next = INIT_ROM[init_idx_next];
      ST_FILL:   init_data_next = fill_byte(hdr_cnt_next, pix_cnt_next[0], color_next);
      default:   init_data_next = 9'h100;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg     <= ST_RST_LOW;
      dly_cnt_reg   <= '0;
      init_idx_reg  <= '0;
      hdr_cnt_reg   <= '0;
      pix_cnt_reg   <= '0;
      color_reg     <= '0;
      pending_reg   <= 1'b0;
      lcd_rst_reg   <= 1'b0;
      init_data_reg <= 9'h100;
      en_write_reg  <= 1'b0;
      init_done_reg <= 1'b0;
      fill_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dly_cnt_reg   <= dly_cnt_next;
      init_idx_reg  <= init_idx_next;
      hdr_cnt_reg   <= hdr_cnt_next;
      pix_cnt_reg   <= pix_cnt_next;
      color_reg     <= color_next;
      pending_reg   <= pending_next;
      lcd_rst_reg   <= lcd_rst_next;
      init_data_reg <= init_data_next;
      en_write_reg  <= en_write_next;
      init_done_reg <= init_done_next;
      fill_done_reg <= fill_done_next;
    end
  end

  assign lcd_rst   = lcd_rst_reg;
  assign init_data = init_data_reg;
  assign en_write  = en_write_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign init_done = init_done_reg;
  assign fill_done = fill_done_reg;

endmodule
